// File: rtl/axi4_lite_arb_pkg.sv
// axi4_lite_arb_pkg: FSM state encoding and AXI response codes shared by the arbiter and its bench.
package axi4_lite_arb_pkg;
    typedef enum logic [1:0] {IDLE, RD, WR} state_e;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
endpackage

// File: rtl/axi4_lite_arbiter_if.sv
// axi4_lite_interface: AXI4-Lite bundle; master drives requests, slave drives responses.
interface axi4_lite_interface #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin pick; on a tie the requester not granted last wins.
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       valid_o
);
    assign valid_o = |req_i;
    assign grant_o = &req_i ? ~last_i : req_i[1];
endmodule

// File: rtl/axi4_lite_arbiter.sv
// axi4_lite_arbiter: shares one AXI4-Lite slave between two requesters, one transaction at a time.
module axi4_lite_arbiter
    import axi4_lite_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic                clock,
    input logic                reset,
    axi4_lite_interface.slave  m0,
    axi4_lite_interface.slave  m1,
    axi4_lite_interface.master s
);
    state_e                  state_q, state_d;
    logic                    owner_q, owner_d, last_q, last_d;
    logic                    gnt, gnt_valid;
    logic [1:0]              req;
    logic [ADDR_WIDTH-1:0]   own_araddr, own_awaddr;
    logic [DATA_WIDTH-1:0]   own_wdata;
    logic [DATA_WIDTH/8-1:0] own_wstrb;
    logic                    own_arvalid, own_rready, own_awvalid, own_wvalid, own_bready;
    logic                    rd, wr, r0, r1, w0, w1;

    assign req = {m1.arvalid | m1.awvalid | m1.wvalid, m0.arvalid | m0.awvalid | m0.wvalid};

    rr_arbiter_2 u_rr (
        .req_i  (req),
        .last_i (last_q),
        .grant_o(gnt),
        .valid_o(gnt_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // A master holding both read and write requests is served its read first.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (gnt_valid) begin
                owner_d = gnt;
                last_d  = gnt;
                state_d = (gnt ? m1.arvalid : m0.arvalid) ? RD : WR;
            end
            RD: if (s.rvalid && own_rready) state_d = IDLE;
            WR: if (s.bvalid && own_bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign own_araddr  = owner_q ? m1.araddr  : m0.araddr;
    assign own_arvalid = owner_q ? m1.arvalid : m0.arvalid;
    assign own_rready  = owner_q ? m1.rready  : m0.rready;
    assign own_awaddr  = owner_q ? m1.awaddr  : m0.awaddr;
    assign own_awvalid = owner_q ? m1.awvalid : m0.awvalid;
    assign own_wdata   = owner_q ? m1.wdata   : m0.wdata;
    assign own_wstrb   = owner_q ? m1.wstrb   : m0.wstrb;
    assign own_wvalid  = owner_q ? m1.wvalid  : m0.wvalid;
    assign own_bready  = owner_q ? m1.bready  : m0.bready;

    assign rd = state_q == RD;
    assign wr = state_q == WR;
    assign r0 = rd & ~owner_q;
    assign r1 = rd &  owner_q;
    assign w0 = wr & ~owner_q;
    assign w1 = wr &  owner_q;

    assign s.araddr  = rd ? own_araddr : '0;
    assign s.arvalid = rd & own_arvalid;
    assign s.rready  = rd & own_rready;
    assign s.awaddr  = wr ? own_awaddr : '0;
    assign s.awvalid = wr & own_awvalid;
    assign s.wdata   = wr ? own_wdata : '0;
    assign s.wstrb   = wr ? own_wstrb : '0;
    assign s.wvalid  = wr & own_wvalid;
    assign s.bready  = wr & own_bready;

    assign m0.arready = r0 & s.arready;
    assign m0.rvalid  = r0 & s.rvalid;
    assign m0.rdata   = r0 ? s.rdata : '0;
    assign m0.rresp   = r0 ? s.rresp : '0;
    assign m0.awready = w0 & s.awready;
    assign m0.wready  = w0 & s.wready;
    assign m0.bvalid  = w0 & s.bvalid;
    assign m0.bresp   = w0 ? s.bresp : '0;

    assign m1.arready = r1 & s.arready;
    assign m1.rvalid  = r1 & s.rvalid;
    assign m1.rdata   = r1 ? s.rdata : '0;
    assign m1.rresp   = r1 ? s.rresp : '0;
    assign m1.awready = w1 & s.awready;
    assign m1.wready  = w1 & s.wready;
    assign m1.bvalid  = w1 & s.bvalid;
    assign m1.bresp   = w1 ? s.bresp : '0;
endmodule
